mem_read_arbiter: RTL and testbench

Shares one downstream memory read port between the instruction fetch path and the data load path of the core. Arbitrates between the two `sys::mem_read_req_t` requesters, holds a grant until the memory completes, and routes the `sys::mem_read_rsp_t` back to the granted requester only. Uses data-first priority with a starvation bound for fetch, plus a watchdog that terminates hung transactions with an error response. Sits between the fetch/memory stages and the memory system interface.

---
 rtl/mem_read_arbiter_pkg.sv | 36 +++
 rtl/arb_watchdog.sv | 28 ++
 rtl/mem_read_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_read_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_read_arbiter_pkg.sv
// Request/response types, FSM state codes and defaults shared by the read-port arbiter.
package mem_read_arbiter_pkg;

    typedef struct packed {
        logic        en;
        logic [31:0] addr;
        logic [3:0]  mask;
    } mem_read_req_t;

    typedef struct packed {
        logic        valid;
        logic        done;
        logic [31:0] data;
    } mem_read_rsp_t;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t IDLE       = 2'd0;
    localparam arb_state_t GRANT_INST = 2'd1;
    localparam arb_state_t GRANT_DATA = 2'd2;

    localparam mem_read_rsp_t mem_read_rsp_idle = '0;
    localparam mem_read_req_t mem_read_req_idle = '0;

    localparam int unsigned DEFAULT_STARVE_LIMIT = 4;
    localparam int unsigned DEFAULT_TIMEOUT      = 64;

    // Terminating response: completes the transaction without valid data.
    function automatic mem_read_rsp_t timeout_rsp();
        mem_read_rsp_t rsp;
        rsp      = mem_read_rsp_idle;
        rsp.done = 1'b1;
        return rsp;
    endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Grant-age counter; o_expired flags the last cycle a grant may wait for completion.
module arb_watchdog
    import mem_read_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [15:0] EXPIRE_AT = 16'(TIMEOUT - 1);

    logic [15:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign o_expired = i_enable && (r_count == EXPIRE_AT);

endmodule

// File: rtl/mem_read_arbiter.sv
// Shares one memory read port between fetch and load: data-first with a fetch starvation
// bound, grant held until done, and a watchdog that terminates hung transactions.
module mem_read_arbiter
    import mem_read_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = DEFAULT_STARVE_LIMIT,
    parameter int unsigned TIMEOUT      = DEFAULT_TIMEOUT
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  mem_read_req_t i_inst_req,
    output mem_read_rsp_t o_inst_rsp,
    input  mem_read_req_t i_data_req,
    output mem_read_rsp_t o_data_rsp,
    output mem_read_req_t o_mem_req,
    input  mem_read_rsp_t i_mem_rsp,
    output logic          o_busy
);

    localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

    arb_state_t    r_state;
    arb_state_t    w_state_next;
    logic [7:0]    r_starve_cnt;
    logic [7:0]    w_starve_next;
    mem_read_req_t w_owner_req;
    mem_read_rsp_t w_owner_rsp;
    logic          w_granted;
    logic          w_done;
    logic          w_abort;
    logic          w_expired;
    logic          w_timeout;
    logic          w_select;
    logic          w_win_data;
    logic          w_win_inst;
    logic          w_wd_clear;

    // Abort outranks the watchdog: an owner that withdrew gets no terminating response.
    always_comb begin
        w_granted   = (r_state == GRANT_INST) || (r_state == GRANT_DATA);
        w_owner_req = (r_state == GRANT_DATA) ? i_data_req : i_inst_req;
        w_done      = w_granted && i_mem_rsp.done;
        w_abort     = w_granted && !i_mem_rsp.done && !w_owner_req.en;
        w_timeout   = w_expired && !i_mem_rsp.done && !w_abort;
        w_select    = !w_granted || w_done || w_timeout;
        w_wd_clear  = w_select || w_abort;
    end

    always_comb begin
        w_win_data = i_data_req.en && ((r_starve_cnt < STARVE_MAX) || !i_inst_req.en);
        w_win_inst = i_inst_req.en && !w_win_data;
    end

    always_comb begin
        w_state_next = r_state;
        if (w_select) begin
            if (w_win_data) begin
                w_state_next = GRANT_DATA;
            end else if (w_win_inst) begin
                w_state_next = GRANT_INST;
            end else begin
                w_state_next = IDLE;
            end
        end else if (w_abort) begin
            w_state_next = IDLE;
        end
    end

    always_comb begin
        w_starve_next = r_starve_cnt;
        if (!i_inst_req.en || (w_select && w_win_inst)) begin
            w_starve_next = '0;
        end else if (w_select && w_win_data && (r_starve_cnt < STARVE_MAX)) begin
            w_starve_next = r_starve_cnt + 8'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_starve_cnt <= '0;
        end else begin
            r_state      <= w_state_next;
            r_starve_cnt <= w_starve_next;
        end
    end

    arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clear   (w_wd_clear),
        .i_enable  (w_granted),
        .o_expired (w_expired)
    );

    always_comb begin
        w_owner_rsp = i_mem_rsp;
        if (w_abort) begin
            w_owner_rsp = mem_read_rsp_idle;
        end else if (w_timeout) begin
            w_owner_rsp = timeout_rsp();
        end

        o_mem_req  = mem_read_req_idle;
        o_inst_rsp = mem_read_rsp_idle;
        o_data_rsp = mem_read_rsp_idle;
        if (w_granted) begin
            o_mem_req.en   = w_owner_req.en && !w_timeout;
            o_mem_req.addr = w_owner_req.addr;
            o_mem_req.mask = w_owner_req.mask;
        end
        if (r_state == GRANT_INST) begin
            o_inst_rsp = w_owner_rsp;
        end
        if (r_state == GRANT_DATA) begin
            o_data_rsp = w_owner_rsp;
        end
        o_busy = w_granted;
    end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed test-plan steps followed by a randomized run, all checked against a cycle model.
module tb_mem_read_arbiter;
    import mem_read_arbiter_pkg::*;

    localparam int STARVE_LIMIT = 4;
    localparam int TIMEOUT      = 64;

    logic          clk;
    logic          rst;
    mem_read_req_t inst_req;
    mem_read_req_t data_req;
    mem_read_req_t mem_req;
    mem_read_rsp_t inst_rsp;
    mem_read_rsp_t data_rsp;
    mem_read_rsp_t mem_rsp;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_read_arbiter #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .TIMEOUT      (TIMEOUT)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_inst_req (inst_req),
        .o_inst_rsp (inst_rsp),
        .i_data_req (data_req),
        .o_data_rsp (data_rsp),
        .o_mem_req  (mem_req),
        .i_mem_rsp  (mem_rsp),
        .o_busy     (busy)
    );

    // Reference model: owner 0 = none, 1 = fetch, 2 = load; age = cycles spent in the grant.
    int            m_owner, m_age, m_starve;
    int            n_owner, n_age, n_starve;
    bit            chk_on;
    mem_read_req_t e_mem;
    mem_read_rsp_t e_inst, e_data;
    logic          e_busy;
    mem_read_req_t s_mem;
    mem_read_rsp_t s_inst, s_data;
    logic          s_busy;
    string         order;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_eval();
        mem_read_req_t own;
        mem_read_rsp_t grsp;
        bit granted, done, abort, tmo, sel;
        int win;
        granted = (m_owner != 0);
        own     = (m_owner == 2) ? data_req : inst_req;
        done    = granted && mem_rsp.done;
        abort   = granted && !done && !own.en;
        tmo     = granted && !done && !abort && (m_age == TIMEOUT - 1);
        sel     = !granted || done || tmo;
        if (data_req.en && m_starve < STARVE_LIMIT) win = 2;
        else if (inst_req.en) win = 1;
        else if (data_req.en) win = 2;
        else win = 0;

        e_mem  = '0;
        e_inst = '0;
        e_data = '0;
        e_busy = granted;
        if (granted) begin
            e_mem.en   = own.en && !tmo;
            e_mem.addr = own.addr;
            e_mem.mask = own.mask;
            grsp = mem_rsp;
            if (abort) grsp = '0;
            else if (tmo) begin
                grsp      = '0;
                grsp.done = 1'b1;
            end
            if (m_owner == 1) e_inst = grsp;
            else e_data = grsp;
        end

        if (rst) begin
            n_owner  = 0;
            n_age    = 0;
            n_starve = 0;
        end else begin
            n_owner = sel ? win : (abort ? 0 : m_owner);
            n_age   = (sel || abort) ? 0 : m_age + 1;
            if (!inst_req.en || (sel && win == 1)) n_starve = 0;
            else if (sel && win == 2) n_starve = (m_starve + 1 > STARVE_LIMIT) ? STARVE_LIMIT
                                                                               : m_starve + 1;
            else n_starve = m_starve;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_eval();
        s_mem  = mem_req;
        s_inst = inst_rsp;
        s_data = data_rsp;
        s_busy = busy;
        if (chk_on) begin
            chk("mem_req", 64'(mem_req), 64'(e_mem));
            chk("inst_rsp", 64'(inst_rsp), 64'(e_inst));
            chk("data_rsp", 64'(data_rsp), 64'(e_data));
            chk("busy", 64'(busy), 64'(e_busy));
        end
        @(posedge clk);
        m_owner  = n_owner;
        m_age    = n_age;
        m_starve = n_starve;
        #1;
    endtask

    initial begin
        int hang;
        chk_on   = 1'b0;
        rst      = 1'b1;
        inst_req = '0;
        data_req = '0;
        mem_rsp  = '0;
        m_owner  = 0;
        m_age    = 0;
        m_starve = 0;
        tick();
        tick();
        chk_on = 1'b1;
        tick();
        chk("reset_busy", 64'(s_busy), 64'h0);
        chk("reset_starve", 64'(dut.r_starve_cnt), 64'h0);
        chk("reset_wd", 64'(dut.u_watchdog.r_count), 64'h0);
        rst = 1'b0;

        // Single fetch, done on the fourth grant cycle.
        inst_req = '{en: 1'b1, addr: 32'h100, mask: 4'hF};
        tick();
        chk("fetch_idle_en", 64'(s_mem.en), 64'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("fetch_addr", 64'(s_mem.addr), 64'h100);
            chk("fetch_nodone", 64'(s_inst.done), 64'h0);
        end
        mem_rsp = '{valid: 1'b1, done: 1'b1, data: 32'hDEADBEEF};
        tick();
        chk("fetch_rsp", 64'(s_inst), 64'({1'b1, 1'b1, 32'hDEADBEEF}));
        chk("fetch_data_quiet", 64'(s_data), 64'h0);
        mem_rsp  = '0;
        inst_req.en = 1'b0;
        tick();
        tick();

        // Contention with single-cycle memory.
        inst_req = '{en: 1'b1, addr: 32'h200, mask: 4'h3};
        data_req = '{en: 1'b1, addr: 32'h300, mask: 4'hC};
        mem_rsp  = '{valid: 1'b1, done: 1'b1, data: 32'h12345678};
        tick();
        order = "";
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("contend_busy", 64'(s_busy), 64'h1);
            if (s_data.done) order = {order, "D"};
            else if (s_inst.done) order = {order, "I"};
            else order = {order, "-"};
        end
        n_checks++;
        assert (order == "DDDDIDDDDI") else begin
            n_fail++;
            $error("FAIL contend_order: observed %s, expected DDDDIDDDDI", order);
        end
        inst_req.en = 1'b0;
        data_req.en = 1'b0;
        mem_rsp = '0;
        tick();
        tick();

        // Watchdog expiry on the 64th grant cycle.
        data_req = '{en: 1'b1, addr: 32'h400, mask: 4'hF};
        tick();
        for (int k = 0; k < TIMEOUT - 1; k++) tick();
        tick();
        chk("wd_done", 64'(s_data.done), 64'h1);
        chk("wd_valid", 64'(s_data.valid), 64'h0);
        chk("wd_mem_en", 64'(s_mem.en), 64'h0);
        data_req.en = 1'b0;
        tick();
        tick();
        chk("wd_idle", 64'(s_busy), 64'h0);

        // Abort by fetch with a load waiting.
        inst_req = '{en: 1'b1, addr: 32'h500, mask: 4'h1};
        tick();
        tick();
        tick();
        inst_req.en = 1'b0;
        data_req = '{en: 1'b1, addr: 32'h600, mask: 4'h2};
        tick();
        chk("abort_nodone", 64'(s_inst.done), 64'h0);
        chk("abort_mem_en", 64'(s_mem.en), 64'h0);
        tick();
        chk("abort_idle", 64'(s_busy), 64'h0);
        tick();
        chk("abort_data_en", 64'(s_mem.en), 64'h1);
        chk("abort_data_addr", 64'(s_mem.addr), 64'h600);

        // Reset mid-transaction with done on the reset cycle.
        inst_req = '{en: 1'b1, addr: 32'h700, mask: 4'h4};
        mem_rsp  = '{valid: 1'b1, done: 1'b1, data: 32'hA5A5A5A5};
        tick();
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        mem_rsp  = '0;
        inst_req = '0;
        data_req = '0;
        tick();
        chk("rst_busy", 64'(s_busy), 64'h0);
        chk("rst_mem", 64'(s_mem), 64'h0);
        chk("rst_inst", 64'(s_inst), 64'h0);
        chk("rst_data", 64'(s_data), 64'h0);
        chk("rst_starve", 64'(dut.r_starve_cnt), 64'h0);
        chk("rst_wd", 64'(dut.u_watchdog.r_count), 64'h0);

        // Done coinciding with watchdog expiry.
        data_req = '{en: 1'b1, addr: 32'h800, mask: 4'hF};
        tick();
        for (int k = 0; k < TIMEOUT - 1; k++) tick();
        mem_rsp = '{valid: 1'b1, done: 1'b1, data: 32'hCAFEF00D};
        tick();
        chk("sim_rsp", 64'(s_data), 64'({1'b1, 1'b1, 32'hCAFEF00D}));
        chk("sim_mem_en", 64'(s_mem.en), 64'h1);
        mem_rsp = '0;
        data_req.en = 1'b0;
        tick();
        tick();

        // Randomized traffic with occasional hung memory and resets.
        hang = 0;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            if (inst_req.en) begin
                if (hang == 0 && $urandom_range(0, 9) == 0) inst_req.en = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                inst_req.en   = 1'b1;
                inst_req.addr = $urandom;
                inst_req.mask = 4'($urandom);
            end
            if (data_req.en) begin
                if (hang == 0 && $urandom_range(0, 9) == 0) data_req.en = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                data_req.en   = 1'b1;
                data_req.addr = $urandom;
                data_req.mask = 4'($urandom);
            end
            if (hang > 0) hang--;
            else if ($urandom_range(0, 149) == 0) hang = 80;
            mem_rsp.done  = (hang == 0) && ($urandom_range(0, 3) == 0);
            mem_rsp.valid = 1'($urandom);
            mem_rsp.data  = $urandom;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
